round_robin_arbiter4: RTL and testbench

Four-way round-robin arbiter that shares one downstream resource (SD card command/data path, display bus) between four requesters. It produces a 2-bit grant index and the matching one-hot grant bus, using the same index-to-one-hot mapping as the 2-bit decoder (index 3 maps to 4'b1000, index 0 maps to 4'b0001). It sits between the requesting front-end blocks and the shared resource's select/enable inputs.

---
 rtl/round_robin_arbiter4.sv | 124 ++++++++++++
 tb/tb_round_robin_arbiter4.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter4.sv
// round_robin_arbiter4: four-way round-robin arbiter with registered one-hot grant and index.
// Optional hold timeout with per-requester blocking is built when ARB_TIMEOUT_EN is defined.
module round_robin_arbiter4 #(
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] request,
  output logic [3:0] grantOut,
  output logic [1:0] grantIndex,
  output logic       grantValid,
  output logic       timeoutPulse
);

  if (HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W) - 1) begin : g_bad_hold_max
    $error("round_robin_arbiter4: HOLD_MAX outside 1..2^CNT_W-1");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] index_q, index_d;
  logic [1:0] last_q, last_d;
  logic [3:0] blocked;
  logic [3:0] eligible;
  logic       hold_expired;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       blocked_q;
  logic             pulse_q;
  logic             revoke;

  assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign revoke       = (state_q == BUSY) && request[index_q] && hold_expired;
  assign blocked      = blocked_q;

  // Blocked bits persist only while the requester keeps its request high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      blocked_q <= 4'b0000;
      pulse_q   <= 1'b0;
    end else begin
      cnt_q     <= (state_q == BUSY) ? cnt_q + 1'b1 : '0;
      blocked_q <= (blocked_q & request) | (revoke ? grant_q : 4'b0000);
      pulse_q   <= revoke;
    end
  end

  assign timeoutPulse = pulse_q;
`else
  assign hold_expired = 1'b0;
  assign blocked      = 4'b0000;
  assign timeoutPulse = 1'b0;
`endif

  assign eligible = request & ~blocked;

  // Search upward from the requester after the last owner, wrapping 3 -> 0.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    index_d = index_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = 4'b0001 << winner;
          index_d = winner;
          last_d  = winner;
        end
      end
      BUSY: begin
        if (!request[index_q] || hold_expired) begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      index_q <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign grantOut   = grant_q;
  assign grantIndex = index_q;
  assign grantValid = |grant_q;

endmodule

// File: tb/tb_round_robin_arbiter4.sv
// Testbench for round_robin_arbiter4: directed test-plan steps plus randomized requests
// compared cycle by cycle against an owner/priority reference model.
module tb_round_robin_arbiter4;

  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] request = 4'b0000;
  logic [3:0] grantOut;
  logic [1:0] grantIndex;
  logic       grantValid;
  logic       timeoutPulse;

  int tests_run = 0;
  int failed    = 0;

  // Reference model state: owner is -1 when nobody holds the resource.
  int       m_owner;
  int       m_idx;
  int       m_last;
  int       m_hold;
  bit       m_pulse;
  bit [3:0] m_blk;

  round_robin_arbiter4 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .request      (request),
    .grantOut     (grantOut),
    .grantIndex   (grantIndex),
    .grantValid   (grantValid),
    .timeoutPulse (timeoutPulse)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_owner = -1;
    m_idx   = 0;
    m_last  = 3;
    m_hold  = 0;
    m_pulse = 1'b0;
    m_blk   = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] req);
    bit [3:0] elig;
    int       win;
    m_pulse = 1'b0;
    elig    = req & ~m_blk;
    m_blk   = m_blk & req;
    if (m_owner >= 0) begin
      if (!req[m_owner]) m_owner = -1;
`ifdef ARB_TIMEOUT_EN
      else if (m_hold >= HOLD) begin
        m_blk[m_owner] = 1'b1;
        m_pulse        = 1'b1;
        m_owner        = -1;
      end else m_hold++;
`endif
    end else begin
      win = -1;
      for (int k = 1; k <= 4; k++)
        if (win < 0 && elig[(m_last + k) % 4]) win = (m_last + k) % 4;
      if (win >= 0) begin
        m_owner = win;
        m_idx   = win;
        m_last  = win;
        m_hold  = 1;
      end
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, 2'(m_idx), (m_owner >= 0), m_pulse};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {grantOut, grantIndex, grantValid, timeoutPulse};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request pattern across one rising edge and compare against the model.
  task automatic cycle(input logic [3:0] req, input string tag);
    request = req;
    @(posedge clock);
    model_step(req);
    #1;
    check(tag, dut_vec(), model_vec());
  endtask

  initial begin
    logic [3:0] r;
    model_reset();

    // Reset state
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_state", dut_vec(), 8'h00);
    reset = 1'b0;

    cycle(4'b1111, "first_grant");
    check("first_grant_onehot", {4'b0, grantOut}, 8'h01);
    cycle(4'b1111, "hold_grant");

    // Asynchronous reset in the middle of a grant
    reset = 1'b1;
    #1;
    check("async_reset_clears", dut_vec(), 8'h00);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle(4'b1111, "grant_after_reset");
    check("after_reset_req0", {4'b0, grantOut}, 8'h01);
    cycle(4'b0000, "release_after_reset");

    // Single requester
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0100, "single_req");
      check("single_index", {6'b0, grantIndex}, 8'h02);
    end
    cycle(4'b0000, "single_drop");
    check("single_clear", {4'b0, grantOut}, 8'h00);

    // Full rotation from a fresh reset
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, "rot_grant");
      check("rot_order", {6'b0, grantIndex}, 8'(k % 4));
      cycle(4'b1111, "rot_hold");
      cycle(4'b1111, "rot_hold");
      cycle(4'b1111 & ~(4'b0001 << (k % 4)), "rot_release");
      check("rot_gap", {7'b0, grantValid}, 8'h00);
    end

    // Wrap priority: last owner 2, then requesters 0 and 3
    cycle(4'b0100, "wrap_setup");
    cycle(4'b0000, "wrap_setup_rel");
    cycle(4'b1001, "wrap_grant3");
    check("wrap_winner3", {6'b0, grantIndex}, 8'h03);
    cycle(4'b0001, "wrap_rel3");
    cycle(4'b0001, "wrap_grant0");
    check("wrap_winner0", {4'b0, grantOut}, 8'h01);
    cycle(4'b0000, "wrap_rel0");

    // No preemption
    cycle(4'b0010, "nopre_grant1");
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0011, "nopre_hold");
      check("nopre_stays1", {4'b0, grantOut}, 8'h02);
    end
    cycle(4'b0001, "nopre_rel1");
    cycle(4'b0001, "nopre_grant0");
    cycle(4'b0000, "nopre_rel0");

`ifdef ARB_TIMEOUT_EN
    // Timeout: requester 1 holds past HOLD_MAX while requester 2 waits
    cycle(4'b0110, "to_grant1");
    for (int i = 0; i < HOLD - 1; i++) cycle(4'b0110, "to_hold");
    cycle(4'b0110, "to_revoke");
    check("to_pulse", {7'b0, timeoutPulse}, 8'h01);
    cycle(4'b0110, "to_grant2");
    check("to_winner2", {4'b0, grantOut}, 8'h04);
    cycle(4'b0010, "to_rel2");
    cycle(4'b0010, "to_blocked1");
    check("to_no_regrant", {7'b0, grantValid}, 8'h00);
    cycle(4'b0000, "to_unblock");
    cycle(4'b0010, "to_regrant1");
    check("to_regrant_onehot", {4'b0, grantOut}, 8'h02);
    cycle(4'b0000, "to_final_rel");
`endif

    // Randomized level requests, each bit toggling with probability 1/4
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      r = r ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cycle(r, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
